apb_arbiter: RTL and testbench

Round-robin arbiter that shares a single downstream APB bus between N_PORTS upstream APB requesters. Typical requesters are AHB-Lite-to-APB bridges or a debug APB master. It sits between those requesters and the APB peripheral splitter. Each upstream port sees a standard APB slave. The downstream side is one APB master issuing one transfer at a time.

---
 rtl/apb_arbiter_pkg.sv | 16 +
 rtl/apb_arbiter_if.sv | 41 ++++
 rtl/apb_arbiter_rr_priority_select.sv | 41 ++++
 rtl/apb_arbiter.sv | 102 ++++++++++
 tb/tb_apb_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_arbiter_pkg.sv
// Shared APB fabric definitions: transfer-phase state encoding and index-width helper.
package apb_arbiter_pkg;

  localparam int W_STATE = 2;

  typedef enum logic [W_STATE-1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } apb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// Bundle of N upstream APB slave ports plus the single downstream APB master port.
// slave modport is the arbiter's view; master modport is the surrounding fabric's view.
interface apb_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
);

  logic [N_PORTS-1:0]         apbs_psel;
  logic [N_PORTS-1:0]         apbs_penable;
  logic [N_PORTS-1:0]         apbs_pwrite;
  logic [N_PORTS*W_PADDR-1:0] apbs_paddr;
  logic [N_PORTS*W_DATA-1:0]  apbs_pwdata;
  logic [N_PORTS-1:0]         apbs_pready;
  logic [N_PORTS*W_DATA-1:0]  apbs_prdata;
  logic [N_PORTS-1:0]         apbs_pslverr;

  logic                       apbm_psel;
  logic                       apbm_penable;
  logic                       apbm_pwrite;
  logic [W_PADDR-1:0]         apbm_paddr;
  logic [W_DATA-1:0]          apbm_pwdata;
  logic                       apbm_pready;
  logic                       apbm_pslverr;
  logic [W_DATA-1:0]          apbm_prdata;

  modport slave (
    input  apbs_psel, apbs_penable, apbs_pwrite, apbs_paddr, apbs_pwdata,
    output apbs_pready, apbs_prdata, apbs_pslverr,
    output apbm_psel, apbm_penable, apbm_pwrite, apbm_paddr, apbm_pwdata,
    input  apbm_pready, apbm_pslverr, apbm_prdata
  );

  modport master (
    output apbs_psel, apbs_penable, apbs_pwrite, apbs_paddr, apbs_pwdata,
    input  apbs_pready, apbs_prdata, apbs_pslverr,
    input  apbm_psel, apbm_penable, apbm_pwrite, apbm_paddr, apbm_pwdata,
    output apbm_pready, apbm_pslverr, apbm_prdata
  );

endinterface

// File: rtl/apb_arbiter_rr_priority_select.sv
// Combinational rotating-priority picker: first eligible requester at or after i_start wins.
module rr_priority_select
  import apb_arbiter_pkg::*;
#(
  parameter  int N_PORTS = 2,
  localparam int W_IDX   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [N_PORTS-1:0] i_excl,
  input  logic [W_IDX-1:0]   i_start,
  output logic [N_PORTS-1:0] o_grant,
  output logic [W_IDX-1:0]   o_idx,
  output logic               o_valid
);

  logic [N_PORTS-1:0] w_elig;
  logic [N_PORTS-1:0] w_rot;
  logic [W_IDX:0]     w_sum;
  logic [W_IDX:0]     w_wrap;

  assign w_elig = i_req & ~i_excl;
  // Rotate so that bit 0 is the start position; the lowest set bit is then the winner.
  assign w_rot  = N_PORTS'({w_elig, w_elig} >> i_start);

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    o_valid = 1'b0;
    w_sum   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_start} + (W_IDX+1)'(i);
      end
    end
  end

  assign w_wrap  = w_sum - (W_IDX+1)'(N_PORTS);
  assign o_idx   = (w_sum >= (W_IDX+1)'(N_PORTS)) ? w_wrap[W_IDX-1:0] : w_sum[W_IDX-1:0];
  assign o_grant = o_valid ? (N_PORTS'(1) << o_idx) : '0;

endmodule

// File: rtl/apb_arbiter.sv
// Shares one downstream APB master among N_PORTS upstream APB requesters.
// APB_ARBITER_RR_EN selects round-robin; otherwise fixed priority (lowest index wins).
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic         clk,
  input  logic         rst,
  apb_arbiter_if.slave bus
);

  localparam int W_IDX = idx_width(N_PORTS);

  apb_state_e         r_state;
  apb_state_e         w_state_nxt;
  logic [W_IDX-1:0]   r_grant;
  logic [N_PORTS-1:0] r_grant_oh;
  logic [W_IDX-1:0]   w_start;
  logic [W_IDX-1:0]   w_win_idx;
  logic [N_PORTS-1:0] w_win_oh;
  logic [N_PORTS-1:0] w_excl;
  logic               w_win_valid;
  logic               w_load;
  logic               w_resp_en;

`ifdef APB_ARBITER_RR_EN
  logic [W_IDX-1:0] r_last;

  assign w_start = (r_last == W_IDX'(N_PORTS - 1)) ? '0 : r_last + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last <= W_IDX'(N_PORTS - 1);
    else if (w_load) r_last <= w_win_idx;
  end
`else
  assign w_start = '0;
`endif

  // The port just served sits out the completion-time arbitration so others cannot starve.
  assign w_excl = (r_state == S_ACCESS) ? r_grant_oh : '0;

  rr_priority_select #(.N_PORTS(N_PORTS)) u_select (
    .i_req   (bus.apbs_psel),
    .i_excl  (w_excl),
    .i_start (w_start),
    .o_grant (w_win_oh),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (bus.apbm_pready) begin
          w_load      = w_win_valid;
          w_state_nxt = w_win_valid ? S_SETUP : S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_oh <= N_PORTS'(1);
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_grant    <= w_win_idx;
        r_grant_oh <= w_win_oh;
      end
    end
  end

  assign bus.apbm_psel    = (r_state != S_IDLE);
  assign bus.apbm_penable = (r_state == S_ACCESS);
  assign bus.apbm_pwrite  = bus.apbs_pwrite[r_grant];
  assign bus.apbm_paddr   = bus.apbs_paddr[r_grant*W_PADDR +: W_PADDR];
  assign bus.apbm_pwdata  = bus.apbs_pwdata[r_grant*W_DATA +: W_DATA];

  // A granted port that abandoned its transfer still lets it finish downstream, but gets no response.
  assign w_resp_en        = (r_state == S_ACCESS) && bus.apbs_psel[r_grant];
  assign bus.apbs_pready  = w_resp_en ? (r_grant_oh & {N_PORTS{bus.apbm_pready}})  : '0;
  assign bus.apbs_pslverr = w_resp_en ? (r_grant_oh & {N_PORTS{bus.apbm_pslverr}}) : '0;
  assign bus.apbs_prdata  = {N_PORTS{bus.apbm_prdata}};

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter with two upstream ports.
module tb_apb_arbiter;

  localparam int N_PORTS = 2;
  localparam int W_PADDR = 16;
  localparam int W_DATA  = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  apb_arbiter_if #(.N_PORTS(N_PORTS), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) bus_if ();

  apb_arbiter #(.N_PORTS(N_PORTS), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive_port(input int p, input logic sel, input logic en, input logic wr,
                            input logic [W_PADDR-1:0] addr, input logic [W_DATA-1:0] wdata);
    bus_if.apbs_psel[p]                      = sel;
    bus_if.apbs_penable[p]                   = en;
    bus_if.apbs_pwrite[p]                    = wr;
    bus_if.apbs_paddr[p*W_PADDR +: W_PADDR]  = addr;
    bus_if.apbs_pwdata[p*W_DATA +: W_DATA]   = wdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.apbm_pready  = 1'b1;
    bus_if.apbm_pslverr = 1'b0;
    bus_if.apbm_prdata  = '0;
    drive_port(0, 1'b0, 1'b0, 1'b0, 16'h0AA0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 1'b0, 16'h0BB0, 32'h0);
    step;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbs_pslverr} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got psel/pen/pready/pslverr=%b want 000000",
               {bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbs_pslverr});
    end
    n_vec++;
    if (bus_if.apbm_paddr !== 16'h0AA0) begin
      n_err++;
      $display("FAIL reset_grant_mux: got paddr=%h want 0aa0", bus_if.apbm_paddr);
    end
    step;
    rst = 1'b0;
    settle;
  endtask

  task automatic test_simultaneous;
    drive_port(0, 1'b1, 1'b0, 1'b1, 16'h0004, 32'h11);
    drive_port(1, 1'b1, 1'b0, 1'b1, 16'h0008, 32'h22);
    settle;
    n_vec++;
    if (bus_if.apbm_psel !== 1'b0) begin
      n_err++; $display("FAIL sim_c0_idle: got psel=%b want 0", bus_if.apbm_psel);
    end
    step;
    bus_if.apbs_penable = 2'b11;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_pwrite, bus_if.apbm_paddr, bus_if.apbm_pwdata}
        !== {3'b101, 16'h0004, 32'h11}) begin
      n_err++;
      $display("FAIL sim_c1_setup0: got ctl=%b addr=%h wdata=%h want ctl=101 addr=0004 wdata=00000011",
               {bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_pwrite}, bus_if.apbm_paddr, bus_if.apbm_pwdata);
    end
    step;
    settle;
    n_vec++;
    if ({bus_if.apbm_penable, bus_if.apbs_pready} !== 3'b1_01) begin
      n_err++; $display("FAIL sim_c2_access0: got pen/pready=%b want 101", {bus_if.apbm_penable, bus_if.apbs_pready});
    end
    step;
    drive_port(0, 1'b0, 1'b0, 1'b0, 16'h0004, 32'h11);
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbm_paddr, bus_if.apbm_pwdata}
        !== {4'b10_00, 16'h0008, 32'h22}) begin
      n_err++;
      $display("FAIL sim_c3_setup1: got ctl=%b addr=%h wdata=%h want ctl=1000 addr=0008 wdata=00000022",
               {bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready}, bus_if.apbm_paddr, bus_if.apbm_pwdata);
    end
    step;
    settle;
    n_vec++;
    if ({bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbm_pwdata} !== {3'b1_10, 32'h22}) begin
      n_err++;
      $display("FAIL sim_c4_access1: got pen/pready=%b wdata=%h want 110 00000022",
               {bus_if.apbm_penable, bus_if.apbs_pready}, bus_if.apbm_pwdata);
    end
    step;
    drive_port(1, 1'b0, 1'b0, 1'b0, 16'h0008, 32'h22);
    settle;
    n_vec++;
    if (bus_if.apbm_psel !== 1'b0) begin
      n_err++; $display("FAIL sim_c5_idle: got psel=%b want 0", bus_if.apbm_psel);
    end
  endtask

  task automatic test_fairness;
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    logic [W_PADDR-1:0] exp_addr;
    logic [N_PORTS-1:0] exp_rdy;
    drive_port(0, 1'b1, 1'b1, 1'b0, 16'h0100, 32'h0);
    drive_port(1, 1'b1, 1'b1, 1'b0, 16'h0200, 32'h0);
    for (int t = 0; t < 6; t++) begin
      exp_addr = (exp_order[t] == 0) ? 16'h0100 : 16'h0200;
      exp_rdy  = (exp_order[t] == 0) ? 2'b01 : 2'b10;
      step;
      settle;
      n_vec++;
      if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_paddr} !== {2'b10, exp_addr}) begin
        n_err++;
        $display("FAIL rr_setup_%0d: got psel/pen=%b addr=%h want 10 addr=%h",
                 t, {bus_if.apbm_psel, bus_if.apbm_penable}, bus_if.apbm_paddr, exp_addr);
      end
      step;
      if (t == 5) drive_port(0, 1'b0, 1'b0, 1'b0, 16'h0100, 32'h0);
      settle;
      n_vec++;
      if ({bus_if.apbm_penable, bus_if.apbs_pready} !== {1'b1, exp_rdy}) begin
        n_err++;
        $display("FAIL rr_access_%0d: got pen/pready=%b want 1%b",
                 t, {bus_if.apbm_penable, bus_if.apbs_pready}, exp_rdy);
      end
    end
    step;
    drive_port(1, 1'b0, 1'b0, 1'b0, 16'h0200, 32'h0);
    settle;
    n_vec++;
    if (bus_if.apbm_psel !== 1'b0) begin
      n_err++; $display("FAIL rr_idle: got psel=%b want 0", bus_if.apbm_psel);
    end
  endtask

  task automatic test_single_read;
    bus_if.apbm_prdata = 32'hCAFEF00D;
    drive_port(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
    settle;
    n_vec++;
    if (bus_if.apbm_psel !== 1'b0) begin
      n_err++; $display("FAIL rd_c0_idle: got psel=%b want 0", bus_if.apbm_psel);
    end
    step;
    bus_if.apbs_penable[0] = 1'b1;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_pwrite, bus_if.apbs_pready, bus_if.apbm_paddr}
        !== {5'b100_00, 16'h0010}) begin
      n_err++;
      $display("FAIL rd_c1_setup: got ctl=%b addr=%h want 10000 addr=0010",
               {bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_pwrite, bus_if.apbs_pready}, bus_if.apbm_paddr);
    end
    step;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbm_paddr}
        !== {4'b11_01, 16'h0010}) begin
      n_err++;
      $display("FAIL rd_c2_access: got ctl=%b addr=%h want 1101 addr=0010",
               {bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready}, bus_if.apbm_paddr);
    end
    n_vec++;
    if (bus_if.apbs_prdata[31:0] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL rd_c2_prdata: got %h want cafef00d", bus_if.apbs_prdata[31:0]);
    end
    step;
    drive_port(0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbs_pready} !== 3'b000) begin
      n_err++; $display("FAIL rd_c3_idle: got psel/pready=%b want 000", {bus_if.apbm_psel, bus_if.apbs_pready});
    end
  endtask

  task automatic test_wait_error;
    drive_port(1, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h5A5A5A5A);
    bus_if.apbm_pready = 1'b0;
    step;
    bus_if.apbs_penable[1] = 1'b1;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_paddr} !== {2'b10, 16'h0020}) begin
      n_err++;
      $display("FAIL we_setup: got psel/pen=%b addr=%h want 10 addr=0020",
               {bus_if.apbm_psel, bus_if.apbm_penable}, bus_if.apbm_paddr);
    end
    for (int w = 0; w < 3; w++) begin
      step;
      settle;
      n_vec++;
      if ({bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbs_pslverr} !== 5'b1_00_00) begin
        n_err++;
        $display("FAIL we_wait_%0d: got pen/pready/pslverr=%b want 10000",
                 w, {bus_if.apbm_penable, bus_if.apbs_pready, bus_if.apbs_pslverr});
      end
    end
    step;
    bus_if.apbm_pready  = 1'b1;
    bus_if.apbm_pslverr = 1'b1;
    settle;
    n_vec++;
    if ({bus_if.apbs_pready, bus_if.apbs_pslverr} !== 4'b10_10) begin
      n_err++;
      $display("FAIL we_done: got pready/pslverr=%b want 1010", {bus_if.apbs_pready, bus_if.apbs_pslverr});
    end
    step;
    drive_port(1, 1'b0, 1'b0, 1'b0, 16'h0020, 32'h0);
    bus_if.apbm_pslverr = 1'b0;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbs_pready, bus_if.apbs_pslverr} !== 5'b0) begin
      n_err++;
      $display("FAIL we_after: got psel/pready/pslverr=%b want 00000",
               {bus_if.apbm_psel, bus_if.apbs_pready, bus_if.apbs_pslverr});
    end
  endtask

  task automatic test_reset_mid_access;
    drive_port(0, 1'b0, 1'b0, 1'b0, 16'h0400, 32'h0);
    drive_port(1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0);
    bus_if.apbm_pready = 1'b0;
    step;
    bus_if.apbs_penable[1] = 1'b1;
    step;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_paddr} !== {2'b11, 16'h0300}) begin
      n_err++;
      $display("FAIL rm_access: got psel/pen=%b addr=%h want 11 addr=0300",
               {bus_if.apbm_psel, bus_if.apbm_penable}, bus_if.apbm_paddr);
    end
    rst = 1'b1;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready} !== 4'b0) begin
      n_err++;
      $display("FAIL rm_async_drop: got psel/pen/pready=%b want 0000",
               {bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbs_pready});
    end
    n_vec++;
    if (bus_if.apbm_paddr !== 16'h0400) begin
      n_err++; $display("FAIL rm_grant_cleared: got paddr=%h want 0400", bus_if.apbm_paddr);
    end
    step;
    rst = 1'b0;
    bus_if.apbm_pready = 1'b1;
    drive_port(0, 1'b1, 1'b0, 1'b0, 16'h0400, 32'h0);
    drive_port(1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0);
    step;
    bus_if.apbs_penable = 2'b11;
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_paddr} !== {2'b10, 16'h0400}) begin
      n_err++;
      $display("FAIL rm_port0_first: got psel/pen=%b addr=%h want 10 addr=0400",
               {bus_if.apbm_psel, bus_if.apbm_penable}, bus_if.apbm_paddr);
    end
    step;
    settle;
    n_vec++;
    if (bus_if.apbs_pready !== 2'b01) begin
      n_err++; $display("FAIL rm_port0_ready: got pready=%b want 01", bus_if.apbs_pready);
    end
    step;
    drive_port(0, 1'b0, 1'b0, 1'b0, 16'h0400, 32'h0);
    settle;
    n_vec++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_paddr} !== {2'b10, 16'h0300}) begin
      n_err++;
      $display("FAIL rm_port1_next: got psel/pen=%b addr=%h want 10 addr=0300",
               {bus_if.apbm_psel, bus_if.apbm_penable}, bus_if.apbm_paddr);
    end
    step;
    settle;
    n_vec++;
    if (bus_if.apbs_pready !== 2'b10) begin
      n_err++; $display("FAIL rm_port1_ready: got pready=%b want 10", bus_if.apbs_pready);
    end
    step;
    drive_port(1, 1'b0, 1'b0, 1'b0, 16'h0300, 32'h0);
    settle;
    n_vec++;
    if (bus_if.apbm_psel !== 1'b0) begin
      n_err++; $display("FAIL rm_idle: got psel=%b want 0", bus_if.apbm_psel);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_simultaneous;
    test_fairness;
    test_single_read;
    test_wait_error;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
